fft_pingpong_ram: RTL and testbench
===================================

// Module: fft_pingpong_ram
// PURPOSE
//  Parametrised dual-bank (ping-pong) butterfly memory for the radix-2 FFT datapath.
//  Each bank has two read and two write ports. During a stage, butterflies read from
//    the read bank and write to the write bank; a swap pulse exchanges the roles.
//  Tracks the stage count and registers read data (1-cycle latency) so the
//    twiddle ROM and read data arrive aligned.
// PARAMETERS
//  ADDR_W   6   address bits; bank depth = 2**ADDR_W words (64-point FFT)
//  DATA_W   32  word width (packed complex: re in [DATA_W-1:DATA_W/2], im in low half)
//  STAGES   6   swaps per frame; stage counter wraps after STAGES-1
// PORTS
//  clk        in   1       rising-edge clock
//  reset_n    in   1       asynchronous active-low reset
//  swap       in   1       1-cycle pulse: exchange read/write banks, advance stage
//  write      in   1       write enable for both write ports
//  wr_addr_a  in   ADDR_W  write address, port A
//  wr_addr_b  in   ADDR_W  write address, port B
//  d_a        in   DATA_W  write data, port A
//  d_b        in   DATA_W  write data, port B
//  rd_addr_a  in   ADDR_W  read address, port A
//  rd_addr_b  in   ADDR_W  read address, port B
//  q_a        out  DATA_W  registered read data, port A
//  q_b        out  DATA_W  registered read data, port B
//  rd_bank    out  1       bank currently read (write bank = ~rd_bank)
//  stage      out  $clog2(STAGES)  current stage index
//  last_stage out  1       high while stage == STAGES-1
//  collision  out  1       sticky write-address collision flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, reset_n=0): rd_bank=0, stage=0, last_stage=0 (1 only if STAGES==1),
//    q_a=q_b=0, collision=0. Memory contents are not reset. Reset mid-frame discards
//    stage state immediately. q_* hold 0 until the first clk edge after release.
//  Read: q_x <= bank[rd_bank][rd_addr_x] every cycle. Latency is exactly 1 cycle, with
//    no enable. Both ports may read the same address.
//  Write: when write=1, bank[~rd_bank][wr_addr_a] <= d_a and
//    bank[~rd_bank][wr_addr_b] <= d_b on the same edge.
//  Write collision (write=1, wr_addr_a==wr_addr_b): port B data wins.
//  The read bank is never written, so there is no read-during-write hazard inside a stage.
//  Swap: on a clk edge with swap=1, rd_bank <= ~rd_bank and
//    stage <= (stage==STAGES-1) ? 0 : stage+1.
//    Read and write in the swap cycle use the pre-swap rd_bank. The new roles take
//    effect for addresses presented in the next cycle.
//    Data written in cycle N is readable from rd_addr_x in any cycle after the swap edge.
//  swap held high for k cycles = k swaps (level, evaluated each edge); the driver pulses.
//  last_stage is combinational from stage.
//  The FSM is the 2-state bank pointer {BANK0_RD, BANK1_RD} times the stage counter.
//    Transitions occur only on swap or reset.
// CONFIGURATION
//  FFT_RAM_COLLISION_DETECT_EN defined: collision <= 1 on any edge with write=1 and
//    wr_addr_a==wr_addr_b. It stays 1 until reset_n=0. Port-B-wins write still occurs.
//  Not defined: no compare logic; collision tied to 0. Write behaviour is identical.
// TESTING
//  1. Reset: hold reset_n=0 with clk toggling -> q_a=q_b=0, rd_bank=0, stage=0,
//     collision=0. Release -> values held until the first swap.
//  2. Write A/B: write=1, wr_addr_a=3, d_a=32'h0001_0002, wr_addr_b=35,
//     d_b=32'hFFFF_0003, then swap. Next cycle rd_addr_a=3, rd_addr_b=35 ->
//     one cycle later q_a=32'h0001_0002, q_b=32'hFFFF_0003.
//  3. Isolation: write 32'hDEAD_BEEF to addr 7 without swap. Read addr 7 ->
//     q_a = old read-bank value (not DEADBEEF). After swap -> DEADBEEF.
//  4. Stage wrap: 6 swap pulses -> stage 0,1,...,5,0; last_stage=1 only at stage 5;
//     rd_bank toggles each pulse and ends at 0.
//  5. Collision: write=1, wr_addr_a=wr_addr_b=10, d_a=1, d_b=2, then swap and read 10 ->
//     q_a=2. With FFT_RAM_COLLISION_DETECT_EN: collision=1 and stays 1 until reset.
//     Without: collision=0.
//  6. Swap + write same edge: write addr 4 = 32'h1234_5678 with swap=1 -> data lands
//     in the old write bank, which is readable at addr 4 in the following cycle.
//     A mid-frame reset_n pulse -> stage=0, rd_bank=0 asynchronously.

Source files
------------

// File: rtl/fft_pingpong_ram_if.sv
// Butterfly memory bus: swap/write control, two write ports, two read ports, status.
interface fft_pingpong_ram_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int STAGES = 6
);
    localparam int ST_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic              swap;
    logic              write;
    logic [ADDR_W-1:0] wr_addr_a;
    logic [ADDR_W-1:0] wr_addr_b;
    logic [DATA_W-1:0] d_a;
    logic [DATA_W-1:0] d_b;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] q_a;
    logic [DATA_W-1:0] q_b;
    logic              rd_bank;
    logic [ST_W-1:0]   stage;
    logic              last_stage;
    logic              collision;

    modport master (
        output swap, write, wr_addr_a, wr_addr_b, d_a, d_b, rd_addr_a, rd_addr_b,
        input  q_a, q_b, rd_bank, stage, last_stage, collision
    );

    modport slave (
        input  swap, write, wr_addr_a, wr_addr_b, d_a, d_b, rd_addr_a, rd_addr_b,
        output q_a, q_b, rd_bank, stage, last_stage, collision
    );
endinterface

// File: rtl/fft_pingpong_ram.sv
// Ping-pong butterfly memory with stage tracking and registered dual read ports.
// Optional sticky write-collision flag: define FFT_RAM_COLLISION_DETECT_EN.
//
// state    | meaning
// BANK0_RD | bank 0 is read, bank 1 is written
// BANK1_RD | bank 1 is read, bank 0 is written
module fft_pingpong_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int STAGES = 6
) (
    input logic              clk,
    input logic              reset_n,
    fft_pingpong_ram_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int ST_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [ST_W-1:0] LAST = ST_W'(STAGES - 1);

    typedef enum logic {
        BANK0_RD = 1'b0,
        BANK1_RD = 1'b1
    } bank_t;

    bank_t             state_q, state_d;
    logic [ST_W-1:0]   stage_q, stage_d;
    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];
    logic [DATA_W-1:0] q_a_q, q_b_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BANK0_RD;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        if (bus.swap) begin
            state_d = (state_q == BANK0_RD) ? BANK1_RD : BANK0_RD;
            stage_d = (stage_q == LAST) ? '0 : stage_q + ST_W'(1);
        end
    end

    // Port B is assigned second so it wins when both ports hit one address.
    always_ff @(posedge clk) begin
        if (bus.write) begin
            if (state_q == BANK0_RD) begin
                mem1[bus.wr_addr_a] <= bus.d_a;
                mem1[bus.wr_addr_b] <= bus.d_b;
            end else begin
                mem0[bus.wr_addr_a] <= bus.d_a;
                mem0[bus.wr_addr_b] <= bus.d_b;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_a_q <= '0;
            q_b_q <= '0;
        end else if (state_q == BANK0_RD) begin
            q_a_q <= mem0[bus.rd_addr_a];
            q_b_q <= mem0[bus.rd_addr_b];
        end else begin
            q_a_q <= mem1[bus.rd_addr_a];
            q_b_q <= mem1[bus.rd_addr_b];
        end
    end

`ifdef FFT_RAM_COLLISION_DETECT_EN
    logic coll_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coll_q <= 1'b0;
        end else if (bus.write && (bus.wr_addr_a == bus.wr_addr_b)) begin
            coll_q <= 1'b1;
        end
    end

    assign bus.collision = coll_q;
`else
    assign bus.collision = 1'b0;
`endif

    assign bus.q_a        = q_a_q;
    assign bus.q_b        = q_b_q;
    assign bus.rd_bank    = state_q;
    assign bus.stage      = stage_q;
    assign bus.last_stage = (stage_q == LAST);
endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Bench for fft_pingpong_ram: directed table, hand sequences and random traffic vs a bank model.
module tb_fft_pingpong_ram;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int STAGES = 6;
    localparam int DEPTH  = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    fft_pingpong_ram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STAGES(STAGES)) bus ();

    fft_pingpong_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STAGES(STAGES)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] m_mem [2][DEPTH];
    int m_rb;
    int m_stage;
    bit m_coll;
    bit coll_en;

    typedef struct {
        bit          sw;
        bit          wr;
        logic [5:0]  wa;
        logic [5:0]  wb;
        logic [31:0] da;
        logic [31:0] db;
        logic [5:0]  ra;
        logic [5:0]  rb;
        logic [31:0] qa;
        logic [31:0] qb;
        bit          bank;
        int          stg;
        bit          coll;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rb = 0;
        m_stage = 0;
        m_coll = 1'b0;
    endtask

    // Called at a negedge; returns at the following negedge after checking.
    task automatic step(input bit sw, input bit wr, input logic [5:0] wa, input logic [5:0] wb,
                        input logic [31:0] da, input logic [31:0] db,
                        input logic [5:0] ra, input logic [5:0] rb, input bit chk_q);
        logic [31:0] eqa, eqb;
        bus.swap = sw;
        bus.write = wr;
        bus.wr_addr_a = wa;
        bus.wr_addr_b = wb;
        bus.d_a = da;
        bus.d_b = db;
        bus.rd_addr_a = ra;
        bus.rd_addr_b = rb;
        eqa = m_mem[m_rb][ra];
        eqb = m_mem[m_rb][rb];
        if (wr) begin
            m_mem[1 - m_rb][wa] = da;
            m_mem[1 - m_rb][wb] = db;
            if (coll_en && wa == wb) m_coll = 1'b1;
        end
        if (sw) begin
            m_rb = 1 - m_rb;
            m_stage = (m_stage + 1) % STAGES;
        end
        @(posedge clk);
        @(negedge clk);
        if (chk_q) begin
            check("q_a", bus.q_a, eqa);
            check("q_b", bus.q_b, eqb);
        end
        check("rd_bank", bus.rd_bank, m_rb);
        check("stage", bus.stage, m_stage);
        check("last_stage", bus.last_stage, (m_stage == STAGES - 1));
        check("collision", bus.collision, m_coll);
        bus.swap = 1'b0;
        bus.write = 1'b0;
    endtask

    initial begin
`ifdef FFT_RAM_COLLISION_DETECT_EN
        coll_en = 1'b1;
`else
        coll_en = 1'b0;
`endif
        bus.swap = 0; bus.write = 0; bus.wr_addr_a = 0; bus.wr_addr_b = 0;
        bus.d_a = 0; bus.d_b = 0; bus.rd_addr_a = 0; bus.rd_addr_b = 0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++) m_mem[b][a] = '0;
        model_reset();

        // Reset held with clock running
        repeat (3) @(negedge clk);
        check("rst_q_a", bus.q_a, 0);
        check("rst_q_b", bus.q_b, 0);
        check("rst_rd_bank", bus.rd_bank, 0);
        check("rst_stage", bus.stage, 0);
        check("rst_last", bus.last_stage, 0);
        check("rst_coll", bus.collision, 0);
        reset_n = 1'b1;
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fill bank 1 then bank 0 so every later read is defined
        for (int i = 0; i < 32; i++)
            step(i == 31, 1, 6'(2*i), 6'(2*i+1), 32'hA000_0000 | 32'(2*i),
                 32'hA000_0000 | 32'(2*i+1), 0, 0, 0);
        for (int i = 0; i < 32; i++)
            step(i == 31, 1, 6'(2*i), 6'(2*i+1), 32'hB000_0000 | 32'(2*i),
                 32'hB000_0000 | 32'(2*i+1), 0, 0, 0);
        reset_n = 1'b0;
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;

        //           sw wr wa  wb  da            db            ra  rb  qa            qb            bk st coll
        tbl[0]  = '{0, 1, 3,  35, 32'h0001_0002, 32'hFFFF_0003, 0,  1,  32'hB000_0000, 32'hB000_0001, 0, 0, 0};
        tbl[1]  = '{1, 0, 0,  0,  0,             0,             3,  35, 32'hB000_0003, 32'hB000_0023, 1, 1, 0};
        tbl[2]  = '{0, 0, 0,  0,  0,             0,             3,  35, 32'h0001_0002, 32'hFFFF_0003, 1, 1, 0};
        tbl[3]  = '{0, 1, 7,  8,  32'hDEAD_BEEF, 32'h0000_0008, 7,  8,  32'hA000_0007, 32'hA000_0008, 1, 1, 0};
        tbl[4]  = '{1, 0, 0,  0,  0,             0,             7,  8,  32'hA000_0007, 32'hA000_0008, 0, 2, 0};
        tbl[5]  = '{0, 0, 0,  0,  0,             0,             7,  8,  32'hDEAD_BEEF, 32'h0000_0008, 0, 2, 0};
        tbl[6]  = '{0, 1, 10, 10, 32'h1,         32'h2,         10, 10, 32'hB000_000A, 32'hB000_000A, 0, 2, 1};
        tbl[7]  = '{1, 0, 0,  0,  0,             0,             10, 10, 32'hB000_000A, 32'hB000_000A, 1, 3, 1};
        tbl[8]  = '{0, 0, 0,  0,  0,             0,             10, 11, 32'h0000_0002, 32'hA000_000B, 1, 3, 1};
        tbl[9]  = '{1, 1, 4,  5,  32'h1234_5678, 32'h5555_5555, 4,  5,  32'hA000_0004, 32'hA000_0005, 0, 4, 1};
        tbl[10] = '{0, 0, 0,  0,  0,             0,             4,  5,  32'h1234_5678, 32'h5555_5555, 0, 4, 1};
        tbl[11] = '{1, 0, 0,  0,  0,             0,             0,  63, 32'hB000_0000, 32'hB000_003F, 1, 5, 1};
        tbl[12] = '{1, 0, 0,  0,  0,             0,             4,  4,  32'hA000_0004, 32'hA000_0004, 0, 0, 1};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].sw, tbl[i].wr, tbl[i].wa, tbl[i].wb, tbl[i].da, tbl[i].db,
                 tbl[i].ra, tbl[i].rb, 1);
            check("tbl_q_a", bus.q_a, tbl[i].qa);
            check("tbl_q_b", bus.q_b, tbl[i].qb);
            check("tbl_bank", bus.rd_bank, tbl[i].bank);
            check("tbl_stage", bus.stage, tbl[i].stg);
            check("tbl_last", bus.last_stage, (tbl[i].stg == 5));
            check("tbl_coll", bus.collision, coll_en ? tbl[i].coll : 1'b0);
        end

        // Stage wrap over a full frame of swap pulses
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 0, 0, 0, 1, 2, 1);
            check("wrap_stage", bus.stage, (i + 1) % 6);
            check("wrap_last", bus.last_stage, (i == 4));
            step(0, 0, 0, 0, 0, 0, 3, 4, 1);
        end
        check("wrap_bank_end", bus.rd_bank, 0);

        // Mid-frame asynchronous reset between clock edges
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        check("pre_rst_stage", bus.stage, 3);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_stage", bus.stage, 0);
        check("async_rst_bank", bus.rd_bank, 0);
        check("async_rst_coll", bus.collision, 0);
        check("async_rst_q_a", bus.q_a, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic against the bank model
        for (int i = 0; i < 400; i++) begin
            logic [5:0] wa, wb;
            wa = 6'($urandom_range(0, DEPTH - 1));
            wb = ($urandom_range(0, 7) == 0) ? wa : 6'($urandom_range(0, DEPTH - 1));
            step($urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, wa, wb,
                 $urandom, $urandom,
                 6'($urandom_range(0, DEPTH - 1)), 6'($urandom_range(0, DEPTH - 1)), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
